// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: consumer-side and memory-side buses of the data memory arbiter
interface data_mem_arbiter_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_CONSUMERS = 4
);
  logic [NUM_CONSUMERS-1:0] consumer_read_valid;
  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_read_ready;
  logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_write_valid;
  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_write_ready;
  logic                     mem_read_valid;
  logic [ADDR_BITS-1:0]     mem_read_address;
  logic                     mem_read_ready;
  logic [DATA_BITS-1:0]     mem_read_data;
  logic                     mem_write_valid;
  logic [ADDR_BITS-1:0]     mem_write_address;
  logic [DATA_BITS-1:0]     mem_write_data;
  logic                     mem_write_ready;
  modport master (
    input  consumer_read_valid, consumer_read_address, consumer_write_valid,
           consumer_write_address, consumer_write_data, mem_read_ready,
           mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address, mem_write_valid,
           mem_write_address, mem_write_data
  );
  modport slave (
    output consumer_read_valid, consumer_read_address, consumer_write_valid,
           consumer_write_address, consumer_write_data, mem_read_ready,
           mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address, mem_write_valid,
           mem_write_address, mem_write_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of one data-memory port among load/store channels
module data_mem_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input logic clk,
  input logic reset,
  data_mem_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_CONSUMERS);
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, grant, pick, cand, rr_next;
  logic [NUM_CONSUMERS-1:0] req;
  logic found, is_read, done;
  int j;
  assign req = bus.consumer_read_valid | bus.consumer_write_valid;
  assign rr_next = (grant == PW'(NUM_CONSUMERS - 1)) ? '0 : grant + PW'(1);
  assign done = is_read ? !bus.consumer_read_valid[grant] : !bus.consumer_write_valid[grant];
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    cand = rr_ptr;
    j = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      j = int'(rr_ptr) + k;
      j = (j >= NUM_CONSUMERS) ? j - NUM_CONSUMERS : j;
      cand = PW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick = cand;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = !found ? IDLE : bus.consumer_read_valid[pick] ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:  state_n = bus.mem_read_ready ? RELAY : READ_WAIT;
      WRITE_WAIT: state_n = bus.mem_write_ready ? RELAY : WRITE_WAIT;
      default:    state_n = done ? IDLE : RELAY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      is_read <= 1'b0;
      bus.mem_read_valid <= 1'b0;
      bus.mem_read_address <= '0;
      bus.mem_write_valid <= 1'b0;
      bus.mem_write_address <= '0;
      bus.mem_write_data <= '0;
      bus.consumer_read_ready <= '0;
      bus.consumer_write_ready <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) bus.consumer_read_data[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (found) begin
          grant <= pick;
          is_read <= bus.consumer_read_valid[pick];
          if (bus.consumer_read_valid[pick]) begin
            bus.mem_read_valid <= 1'b1;
            bus.mem_read_address <= bus.consumer_read_address[pick];
          end else begin
            bus.mem_write_valid <= 1'b1;
            bus.mem_write_address <= bus.consumer_write_address[pick];
            bus.mem_write_data <= bus.consumer_write_data[pick];
          end
        end
        READ_WAIT: if (bus.mem_read_ready) begin
          bus.consumer_read_data[grant] <= bus.mem_read_data;
          bus.consumer_read_ready[grant] <= 1'b1;
          bus.mem_read_valid <= 1'b0;
        end
        WRITE_WAIT: if (bus.mem_write_ready) begin
          bus.consumer_write_ready[grant] <= 1'b1;
          bus.mem_write_valid <= 1'b0;
        end
        default: if (done) begin
          bus.consumer_read_ready <= '0;
          bus.consumer_write_ready <= '0;
          rr_ptr <= rr_next;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: vector table, directed corner cases and randomized traffic against a memory model
module tb_data_mem_arbiter;
  localparam int N = 4;
  typedef struct {
    int c;
    bit wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int lat;
    int hold;
    logic [7:0] exp_data;
    int exp_cyc;
    logic [1:0] exp_rr;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int lat = 0;
  bit manual = 1'b0;
  bit man_ready = 1'b0;
  int rcnt = 0;
  int wcnt = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [8:0] ops [$];
  int rereq [N];
  vec_t vt [6];
  int c, n, done_cnt;
  bit busy [N];
  bit r_wr [N];
  logic [7:0] r_addr [N];
  logic [7:0] r_data [N];
  int age [N];
  data_mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) bus ();
  data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.mem_read_ready = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_read_ready = manual & man_ready;
      bus.mem_write_ready = 1'b0;
      if (manual) bus.mem_read_data = 8'hEE;
      else begin
        if (bus.mem_read_valid) begin
          if (rcnt >= lat) begin
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data = mem[bus.mem_read_address];
            rcnt = 0;
          end else rcnt++;
        end else rcnt = 0;
        if (bus.mem_write_valid) begin
          if (wcnt >= lat) begin
            bus.mem_write_ready = 1'b1;
            mem[bus.mem_write_address] = bus.mem_write_data;
            wcnt = 0;
          end else wcnt++;
        end else wcnt = 0;
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    bus.consumer_read_valid = '0;
    bus.consumer_write_valid = '0;
    for (int i = 0; i < N; i++) begin
      bus.consumer_read_address[i] = 8'h00;
      bus.consumer_write_address[i] = 8'h00;
      bus.consumer_write_data[i] = 8'h00;
    end
  endtask
  task automatic check_zero(input string name);
    check({name, "_ready"}, {24'd0, bus.consumer_read_ready, bus.consumer_write_ready}, 32'd0);
    check({name, "_mem"}, {6'd0, bus.mem_read_valid, bus.mem_write_valid, bus.mem_read_address,
                           bus.mem_write_address, bus.mem_write_data}, 32'd0);
    check({name, "_rdata"}, {bus.consumer_read_data[0], bus.consumer_read_data[1],
                             bus.consumer_read_data[2], bus.consumer_read_data[3]}, 32'd0);
    check({name, "_rr"}, 32'(dut.rr_ptr), 32'd0);
  endtask
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    check_zero("reset");
    reset = 1'b0;
  endtask
  task automatic serve(input int cyc);
    logic [N-1:0] again;
    logic prv_r, prv_w;
    again = '0;
    prv_r = bus.mem_read_valid;
    prv_w = bus.mem_write_valid;
    for (int t = 0; t < cyc; t++) begin
      tick();
      if (bus.mem_read_valid && !prv_r) ops.push_back({1'b0, bus.mem_read_address});
      if (bus.mem_write_valid && !prv_w) ops.push_back({1'b1, bus.mem_write_address});
      prv_r = bus.mem_read_valid;
      prv_w = bus.mem_write_valid;
      for (int i = 0; i < N; i++) begin
        if (again[i]) begin
          bus.consumer_read_valid[i] = 1'b1;
          again[i] = 1'b0;
        end else if (bus.consumer_read_ready[i] && bus.consumer_read_valid[i]) begin
          bus.consumer_read_valid[i] = 1'b0;
          if (rereq[i] > 0) begin
            rereq[i]--;
            again[i] = 1'b1;
          end
        end
        if (bus.consumer_write_ready[i]) bus.consumer_write_valid[i] = 1'b0;
      end
    end
  endtask
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    mem[8'h10] = 8'hA5;
    vt[0] = '{c:2, wr:1'b0, addr:8'h10, wdata:8'h00, lat:3, hold:0, exp_data:8'hA5, exp_cyc:5, exp_rr:2'd3};
    vt[1] = '{c:3, wr:1'b1, addr:8'hFF, wdata:8'h5C, lat:0, hold:2, exp_data:8'h00, exp_cyc:2, exp_rr:2'd0};
    vt[2] = '{c:0, wr:1'b0, addr:8'hFF, wdata:8'h00, lat:1, hold:0, exp_data:8'h5C, exp_cyc:3, exp_rr:2'd1};
    vt[3] = '{c:1, wr:1'b0, addr:8'h33, wdata:8'h00, lat:0, hold:1, exp_data:8'h69, exp_cyc:2, exp_rr:2'd2};
    vt[4] = '{c:3, wr:1'b1, addr:8'h00, wdata:8'hC3, lat:2, hold:0, exp_data:8'h00, exp_cyc:4, exp_rr:2'd0};
    vt[5] = '{c:2, wr:1'b0, addr:8'h00, wdata:8'h00, lat:0, hold:0, exp_data:8'hC3, exp_cyc:2, exp_rr:2'd3};
    clear_inputs();
    tick();
    tick();
    check_zero("por");
    reset = 1'b0;
    // round robin from reset, consumers 0 and 1 re-request once
    do_reset();
    lat = 0;
    rereq[0] = 1;
    rereq[1] = 1;
    for (int i = 0; i < N; i++) bus.consumer_read_address[i] = 8'(i);
    bus.consumer_read_valid = 4'hF;
    ops.delete();
    serve(40);
    check("rr_count", 32'(ops.size()), 32'd6);
    for (int k = 0; k < 6 && k < ops.size(); k++) check("rr_order", 32'(ops[k]), 32'(k % 4));
    for (int i = 0; i < N; i++) check("rr_rdata", 32'(bus.consumer_read_data[i]), 32'(8'(i) ^ 8'h5A));
    // table of single transactions
    for (int v = 0; v < 6; v++) begin
      c = vt[v].c;
      lat = vt[v].lat;
      if (vt[v].wr) begin
        bus.consumer_write_address[c] = vt[v].addr;
        bus.consumer_write_data[c] = vt[v].wdata;
        bus.consumer_write_valid[c] = 1'b1;
      end else begin
        bus.consumer_read_address[c] = vt[v].addr;
        bus.consumer_read_valid[c] = 1'b1;
      end
      tick();
      check("vec_mem_valid", 32'(vt[v].wr ? bus.mem_write_valid : bus.mem_read_valid), 32'd1);
      check("vec_mem_addr", 32'(vt[v].wr ? bus.mem_write_address : bus.mem_read_address), 32'(vt[v].addr));
      if (vt[v].wr) check("vec_mem_wdata", 32'(bus.mem_write_data), 32'(vt[v].wdata));
      n = 1;
      while (!(bus.consumer_read_ready[c] | bus.consumer_write_ready[c]) && n < 50) begin
        tick();
        n++;
      end
      check("vec_latency", 32'(n), 32'(vt[v].exp_cyc));
      check("vec_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}),
            vt[v].wr ? 32'(1 << c) : 32'(1 << (c + 4)));
      check("vec_mem_idle", 32'({bus.mem_read_valid, bus.mem_write_valid}), 32'd0);
      if (!vt[v].wr) check("vec_rdata", 32'(bus.consumer_read_data[c]), 32'(vt[v].exp_data));
      for (int h = 0; h < vt[v].hold; h++) begin
        tick();
        check("vec_ready_hold", 32'(bus.consumer_read_ready[c] | bus.consumer_write_ready[c]), 32'd1);
      end
      bus.consumer_read_valid[c] = 1'b0;
      bus.consumer_write_valid[c] = 1'b0;
      tick();
      check("vec_ready_drop", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 32'd0);
      check("vec_rr", 32'(dut.rr_ptr), 32'(vt[v].exp_rr));
    end
    // read before write on one consumer, write waits for its next turn
    do_reset();
    lat = 1;
    bus.consumer_read_address[1] = 8'h20;
    bus.consumer_write_address[1] = 8'h21;
    bus.consumer_write_data[1] = 8'h7E;
    bus.consumer_read_address[2] = 8'h22;
    bus.consumer_read_valid = 4'b0110;
    bus.consumer_write_valid = 4'b0010;
    ops.delete();
    serve(40);
    check("rbw_count", 32'(ops.size()), 32'd3);
    if (ops.size() == 3) begin
      check("rbw_op0", 32'(ops[0]), 32'h020);
      check("rbw_op1", 32'(ops[1]), 32'h022);
      check("rbw_op2", 32'(ops[2]), 32'h121);
    end
    check("rbw_memdata", 32'(mem[8'h21]), 32'h7E);
    check("rbw_rr", 32'(dut.rr_ptr), 32'd2);
    // consumer drops valid while its read is outstanding
    do_reset();
    lat = 3;
    bus.consumer_read_address[0] = 8'h05;
    bus.consumer_read_valid[0] = 1'b1;
    tick();
    check("early_mem_valid", 32'(bus.mem_read_valid), 32'd1);
    bus.consumer_read_valid[0] = 1'b0;
    n = 0;
    while (!bus.consumer_read_ready[0] && n < 20) begin
      tick();
      n++;
    end
    check("early_ready", 32'(bus.consumer_read_ready), 32'd1);
    check("early_rdata", 32'(bus.consumer_read_data[0]), 32'h5F);
    tick();
    check("early_pulse", 32'(bus.consumer_read_ready), 32'd0);
    check("early_rr", 32'(dut.rr_ptr), 32'd1);
    bus.consumer_read_address[1] = 8'h06;
    bus.consumer_read_valid[1] = 1'b1;
    tick();
    check("early_idle", 32'({bus.mem_read_valid, bus.mem_read_address}), 32'h106);
    serve(12);
    // reset while a read is outstanding, then a stray memory ready
    do_reset();
    lat = 1000;
    bus.consumer_read_address[2] = 8'h10;
    bus.consumer_read_valid[2] = 1'b1;
    tick();
    check("rst_mid_busy", 32'({bus.mem_read_valid, bus.mem_read_address}), 32'h110);
    tick();
    reset = 1'b1;
    tick();
    check_zero("rst_mid");
    reset = 1'b0;
    bus.consumer_read_valid[2] = 1'b0;
    manual = 1'b1;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    check("late_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 32'd0);
    check("late_rdata", 32'(bus.consumer_read_data[2]), 32'd0);
    check("late_mem", 32'(bus.mem_read_valid), 32'd0);
    manual = 1'b0;
    lat = 0;
    bus.consumer_read_address[3] = 8'h07;
    bus.consumer_read_valid[3] = 1'b1;
    tick();
    check("post_rst_grant", 32'({bus.mem_read_valid, bus.mem_read_address}), 32'h107);
    serve(10);
    // randomized traffic against a serialized memory model
    do_reset();
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'($urandom);
      ref_mem[a] = mem[a];
    end
    for (int i = 0; i < N; i++) busy[i] = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      check("rnd_one_ready", 32'($countones({bus.consumer_read_ready, bus.consumer_write_ready}) <= 1), 32'd1);
      check("rnd_one_mem", 32'(bus.mem_read_valid & bus.mem_write_valid), 32'd0);
      lat = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        if (busy[i]) begin
          age[i]++;
          if (r_wr[i] ? bus.consumer_write_ready[i] : bus.consumer_read_ready[i]) begin
            if (r_wr[i]) begin
              ref_mem[r_addr[i]] = r_data[i];
              bus.consumer_write_valid[i] = 1'b0;
            end else begin
              check("rnd_read", 32'(bus.consumer_read_data[i]), 32'(ref_mem[r_addr[i]]));
              bus.consumer_read_valid[i] = 1'b0;
            end
            busy[i] = 1'b0;
            done_cnt++;
          end else if (age[i] > 200) begin
            check("rnd_timeout", 32'(age[i]), 32'd200);
            bus.consumer_read_valid[i] = 1'b0;
            bus.consumer_write_valid[i] = 1'b0;
            busy[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          busy[i] = 1'b1;
          age[i] = 0;
          r_wr[i] = 1'($urandom_range(0, 1));
          r_addr[i] = 8'($urandom_range(0, 15));
          r_data[i] = 8'($urandom);
          if (r_wr[i]) begin
            bus.consumer_write_address[i] = r_addr[i];
            bus.consumer_write_data[i] = r_data[i];
            bus.consumer_write_valid[i] = 1'b1;
          end else begin
            bus.consumer_read_address[i] = r_addr[i];
            bus.consumer_read_valid[i] = 1'b1;
          end
        end
      end
    end
    check("rnd_done_count", 32'(done_cnt > 100), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
